hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline stall and flush sequencer for the 5-stage MIPS core. It watches the ID-stage source operands, the ID/EXE register outputs, and the MEM-stage memory handshake. From these it drives the enable and synchronous-clear inputs of the PC, IF/ID, ID/EXE and EXE/MEM registers. It inserts load-use bubbles, squashes wrong-path instructions after a taken branch or jump, and freezes the pipe during multi-cycle memory accesses.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..3).
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before forced release (1..65535).
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs, id_rt  in  5 each  ID-stage source register numbers.
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
- exe_mem_rd  in  1  instruction in EXE is a load.
- exe_wb_we  in  1  instruction in EXE writes a GPR.
- exe_wb_dreg  in  5  destination GPR of the instruction in EXE.
- exe_bj  in  1  branch/jump in EXE resolved taken this cycle.
- mem_req  in  1  MEM stage has an access outstanding.
- mem_ack  in  1  memory completes the access this cycle.
- pc_en, if_id_en, id_exe_en, exe_mem_en  out  1 each  register enables.
- if_id_flush, id_exe_flush  out  1 each  synchronous clear (bubble) for IF/ID, ID/EXE.
- mem_err  out  1  one-cycle pulse on MEM_WAIT timeout.
- stall_cnt  out  32  saturating count of cycles with pc_en=0.
- flush_cnt  out  32  saturating count of taken-branch flush events.

## Operation
- States: RUN, STALL, MEM_WAIT.
- hz = exe_mem_rd & exe_wb_we & (exe_wb_dreg!=0) & ((id_use_rs & id_rs==exe_wb_dreg) | (id_use_rt & id_rt==exe_wb_dreg)).
- mw = mem_req & ~mem_ack.
- Priority, highest first: mw, then exe_bj, then hz.
- RUN, no event: all enables 1, flushes 0.
- RUN, mw: all enables 0, flushes 0. Go to MEM_WAIT; wait counter = 1.
- RUN, exe_bj: pc_en=1, if_id_en=1, exe_mem_en=1, if_id_flush=1, id_exe_flush=1, flush_cnt+1. Stay in RUN. hz is ignored because the ID instruction is wrong-path.
- RUN, hz: pc_en=0, if_id_en=0, id_exe_en=1, id_exe_flush=1, exe_mem_en=1.
  - If LOAD_BUBBLES>1, go to STALL with bubble counter = LOAD_BUBBLES-1.
  - Otherwise stay in RUN.
- STALL: same outputs as RUN+hz; decrement the counter. At count 1 go to RUN.
  - mw in STALL: MEM_WAIT outputs apply. The bubble counter is held and STALL resumes after mem_ack.
  - exe_bj in STALL: branch outputs apply and the state goes to RUN.
- MEM_WAIT: all enables 0, flushes 0, wait counter +1.
  - mem_ack: return to the saved state (RUN or STALL). Outputs that cycle are still frozen, so the access completes before the pipe advances.
  - Counter reaches MEM_TIMEOUT with no ack: pulse mem_err, return to the saved state.
- Counters saturate at 0xFFFF_FFFF. stall_cnt increments on every cycle with pc_en=0, including MEM_WAIT.

## Timing
- All enable and flush outputs are Mealy: combinational from state and current inputs, same cycle. Only state, counters and mem_err are registered.
- mem_err is asserted in the cycle after the timeout is detected, for exactly one cycle.
- Reset:
  - While rst=1: state=RUN, bubble counter=0, wait counter=0, stall_cnt=0, flush_cnt=0, mem_err=0.
  - While rst=1, outputs force all enables 0 and if_id_flush=id_exe_flush=1, so the pipeline registers clear at the next edge.
- Reset in MEM_WAIT or STALL drops to RUN immediately. No pending state survives reset.
- Load-use latency: exactly LOAD_BUBBLES bubbles enter ID/EXE. The dependent instruction issues in the cycle after the last bubble.
- Simultaneous mem_req & mem_ack on first request: no freeze (mw=0).

## Structure
- Shared package pipe_pkg holds:
  - the state enum {RUN, STALL, MEM_WAIT};
  - the GPR width constant (5) and the R0 constant;
  - the counter width (32).
- One sub-module, sat_counter: a 32-bit saturating incrementer with async reset. It is instantiated twice, for stall_cnt and flush_cnt.
- Hazard compare and priority logic stay inline.

## Test plan
- Load-use, LOAD_BUBBLES=1: exe_mem_rd=1, exe_wb_we=1, exe_wb_dreg=8, id_rs=8, id_use_rs=1 → one cycle with pc_en=0, if_id_en=0, id_exe_flush=1; stall_cnt=1; next cycle all enables 1.
- R0 and unused operand: same as above but exe_wb_dreg=0; or id_use_rs=0 with a matching id_rs → no stall.
- Branch beats hazard: exe_bj=1 and hz=1 together → if_id_flush=id_exe_flush=1, pc_en=1, flush_cnt=1, no stall.
- Memory wait: mem_req=1 with ack after 4 cycles → 4 frozen cycles (all enables 0), stall_cnt=4, then RUN.
- Timeout, MEM_TIMEOUT=3: mem_req held, no ack → mem_err pulses once after 3 wait cycles, then pipe released.
- Reset mid-stall: LOAD_BUBBLES=3, assert rst in the 2nd bubble → state=RUN, counters=0, flushes=1 while rst is high; normal run after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the 5-stage core's pipeline control logic.
//   state_t : hazard sequencer states (RUN, STALL, MEM_WAIT)
//   GPR_W   : width of a GPR register number
//   R0      : the hard-wired zero register, which never carries a real dependency
//   CNT_W   : width of the performance counters
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int GPR_W = 5;
    localparam logic [GPR_W-1:0] R0 = '0;
    localparam int CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with asynchronous active-high reset.
//   clk   : clock
//   rst   : asynchronous reset, clears the count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones once reached
module sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Hold at all-ones so a long run never wraps back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall / flush sequencer for the 5-stage pipeline.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_rs, id_rt             : ID-stage source register numbers
//   id_use_rs, id_use_rt     : ID instruction really reads rs / rt
//   exe_mem_rd               : EXE instruction is a load
//   exe_wb_we, exe_wb_dreg   : EXE instruction writes a GPR, and which one
//   exe_bj                   : branch/jump in EXE resolved taken
//   mem_req, mem_ack         : MEM-stage access outstanding / completing
//   pc_en .. exe_mem_en      : pipeline register enables (combinational)
//   if_id_flush, id_exe_flush: synchronous bubble insertion (combinational)
//   mem_err                  : one-cycle pulse after a memory wait timeout
//   stall_cnt, flush_cnt     : saturating cycles-with-pc_en-low / taken-branch counts
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [GPR_W-1:0] id_rs,
    input  logic [GPR_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             exe_mem_rd,
    input  logic             exe_wb_we,
    input  logic [GPR_W-1:0] exe_wb_dreg,
    input  logic             exe_bj,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]  BUB_INIT = 2'(LOAD_BUBBLES - 1);
    localparam logic [15:0] WAIT_MAX = 16'(MEM_TIMEOUT);

    state_t      state, state_nxt;
    state_t      saved, saved_nxt;
    logic [1:0]  bub_cnt, bub_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        hz, mw, timeout, flush_evt;

    // A load in EXE feeding an operand the ID instruction really reads; R0 never counts.
    assign hz = exe_mem_rd && exe_wb_we && (exe_wb_dreg != R0) &&
                ((id_use_rs && (id_rs == exe_wb_dreg)) ||
                 (id_use_rt && (id_rt == exe_wb_dreg)));

    // An access that completes in the same cycle it is requested needs no freeze.
    assign mw = mem_req && !mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            saved    <= RUN;
            bub_cnt  <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            saved    <= saved_nxt;
            bub_cnt  <= bub_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= timeout;
        end
    end

    // Mealy control: memory freeze beats a taken branch, which beats a load-use bubble.
    always_comb begin
        state_nxt    = state;
        saved_nxt    = saved;
        bub_nxt      = bub_cnt;
        wait_nxt     = wait_cnt;
        timeout      = 1'b0;
        flush_evt    = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_exe_en    = 1'b1;
        exe_mem_en   = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;

        unique case (state)
            RUN, STALL: begin
                if (mw) begin
                    // Freeze everything; the bubble count stays put so STALL resumes afterwards.
                    pc_en      = 1'b0;
                    if_id_en   = 1'b0;
                    id_exe_en  = 1'b0;
                    exe_mem_en = 1'b0;
                    saved_nxt  = state;
                    state_nxt  = MEM_WAIT;
                    wait_nxt   = 16'd1;
                end else if (exe_bj) begin
                    // Both younger instructions are wrong-path, so any pending bubbles are moot.
                    if_id_flush  = 1'b1;
                    id_exe_flush = 1'b1;
                    flush_evt    = 1'b1;
                    state_nxt    = RUN;
                    bub_nxt      = '0;
                end else if ((state == STALL) || hz) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_exe_flush = 1'b1;
                    if (state == STALL) begin
                        if (bub_cnt <= 2'd1) begin
                            state_nxt = RUN;
                            bub_nxt   = '0;
                        end else begin
                            bub_nxt = bub_cnt - 2'd1;
                        end
                    end else if (LOAD_BUBBLES > 1) begin
                        state_nxt = STALL;
                        bub_nxt   = BUB_INIT;
                    end
                end
            end
            MEM_WAIT: begin
                // Still frozen on the ack cycle so the access lands before the pipe moves.
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                id_exe_en  = 1'b0;
                exe_mem_en = 1'b0;
                if (mem_ack) begin
                    state_nxt = saved;
                end else if (wait_cnt >= WAIT_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = saved;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // While reset is held, clear every pipeline register at the next edge.
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_en    = 1'b0;
            exe_mem_en   = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_evt),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Drives two hazard_ctrl instances (LOAD_BUBBLES = 1 and 3, MEM_TIMEOUT = 3) with the
// same inputs and checks them against a cycle-level model of the pipeline rules.
// Control vectors are {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush}.
module tb_hazard_ctrl;

    localparam int TMO = 3;

    localparam logic [5:0] C_RUN    = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_BUBBLE = 6'b001101;
    localparam logic [5:0] C_RESET  = 6'b000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, exe_wb_dreg;
    logic       id_use_rs, id_use_rt, exe_mem_rd, exe_wb_we, exe_bj, mem_req, mem_ack;

    wire [5:0]  ctl0, ctl1;
    wire        err0, err1;
    wire [31:0] stl0, stl1, fls0, fls1;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: bubbles still owed, whether the memory freeze is active and how
    // long it has lasted, the pending error pulse, and plain event tallies.
    int          owed[2], wait_n[2];
    bit          waiting[2], err_q[2];
    int unsigned stalls[2], flushes[2];
    int          n_owed[2], n_wait[2];
    bit          n_waiting[2], n_err[2];
    int unsigned n_stalls[2], n_flushes[2];
    logic [5:0]  exp_ctl[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .exe_mem_rd(exe_mem_rd),
        .exe_wb_we(exe_wb_we), .exe_wb_dreg(exe_wb_dreg), .exe_bj(exe_bj),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(ctl0[5]), .if_id_en(ctl0[4]), .id_exe_en(ctl0[3]), .exe_mem_en(ctl0[2]),
        .if_id_flush(ctl0[1]), .id_exe_flush(ctl0[0]),
        .mem_err(err0), .stall_cnt(stl0), .flush_cnt(fls0)
    );

    hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .exe_mem_rd(exe_mem_rd),
        .exe_wb_we(exe_wb_we), .exe_wb_dreg(exe_wb_dreg), .exe_bj(exe_bj),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(ctl1[5]), .if_id_en(ctl1[4]), .id_exe_en(ctl1[3]), .exe_mem_en(ctl1[2]),
        .if_id_flush(ctl1[1]), .id_exe_flush(ctl1[0]),
        .mem_err(err1), .stall_cnt(stl1), .flush_cnt(fls1)
    );

    function automatic logic [5:0] act_ctl(input int k);
        return (k == 0) ? ctl0 : ctl1;
    endfunction
    function automatic logic act_err(input int k);
        return (k == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] act_stl(input int k);
        return (k == 0) ? stl0 : stl1;
    endfunction
    function automatic logic [31:0] act_fls(input int k);
        return (k == 0) ? fls0 : fls1;
    endfunction

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        exe_mem_rd = 1'b0; exe_wb_we = 1'b0; exe_wb_dreg = 5'd0;
        exe_bj = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        exe_mem_rd = 1'b1; exe_wb_we = 1'b1; exe_wb_dreg = r;
        id_rs = r; id_use_rs = 1'b1;
    endtask

    // Let inputs settle, then work out what each instance must show this cycle and
    // what the model holds after the coming edge.
    task automatic settle();
        bit hz, mw;
        int lb;
        #2;
        hz = exe_mem_rd && exe_wb_we && (exe_wb_dreg != 0) &&
             ((id_use_rs && (id_rs == exe_wb_dreg)) || (id_use_rt && (id_rt == exe_wb_dreg)));
        mw = mem_req && !mem_ack;
        for (int k = 0; k < 2; k++) begin
            lb = (k == 0) ? 1 : 3;
            if (rst) begin
                owed[k] = 0; wait_n[k] = 0; waiting[k] = 0; err_q[k] = 0;
                stalls[k] = 0; flushes[k] = 0;
            end
            n_owed[k] = owed[k]; n_wait[k] = wait_n[k]; n_waiting[k] = waiting[k];
            n_err[k] = 0; n_stalls[k] = stalls[k]; n_flushes[k] = flushes[k];
            if (rst) begin
                exp_ctl[k] = C_RESET;
            end else if (waiting[k]) begin
                exp_ctl[k] = C_FREEZE;
                n_stalls[k]++;
                if (mem_ack) begin
                    n_waiting[k] = 0;
                end else if (wait_n[k] >= TMO) begin
                    n_waiting[k] = 0;
                    n_err[k] = 1;
                end else begin
                    n_wait[k] = wait_n[k] + 1;
                end
            end else if (mw) begin
                exp_ctl[k] = C_FREEZE;
                n_stalls[k]++;
                n_waiting[k] = 1;
                n_wait[k] = 1;
            end else if (exe_bj) begin
                exp_ctl[k] = C_BRANCH;
                n_flushes[k]++;
                n_owed[k] = 0;
            end else if (owed[k] > 0 || hz) begin
                exp_ctl[k] = C_BUBBLE;
                n_stalls[k]++;
                n_owed[k] = (owed[k] > 0) ? owed[k] - 1 : lb - 1;
            end else begin
                exp_ctl[k] = C_RUN;
            end
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            owed[k] = n_owed[k]; wait_n[k] = n_wait[k]; waiting[k] = n_waiting[k];
            err_q[k] = n_err[k]; stalls[k] = n_stalls[k]; flushes[k] = n_flushes[k];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (act_ctl(k) !== C_RESET) begin
                n_fail++;
                $display("[TB] FAIL reset_ctl dut%0d: got %b expected %b", k, act_ctl(k), C_RESET);
            end
            n_cmp++;
            if ({act_err(k), act_stl(k), act_fls(k)} !== 65'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_regs dut%0d: got err=%b stall=%0d flush=%0d expected 0/0/0",
                         k, act_err(k), act_stl(k), act_fls(k));
            end
        end
        advance();
        rst = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_load_use();
        set_load_use(5'd8);
        settle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (act_ctl(k) !== exp_ctl[k]) begin
                n_fail++;
                $display("[TB] FAIL load_use_ctl dut%0d: got %b expected %b", k, act_ctl(k), exp_ctl[k]);
            end
        end
        advance();
        set_idle();
        for (int c = 0; c < 3; c++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act_ctl(k) !== exp_ctl[k]) begin
                    n_fail++;
                    $display("[TB] FAIL load_use_tail dut%0d cycle %0d: got %b expected %b",
                             k, c, act_ctl(k), exp_ctl[k]);
                end
            end
            advance();
        end
        #1;
        n_cmp++;
        if (stl0 !== 32'd1) begin
            n_fail++;
            $display("[TB] FAIL load_use_stall_lb1: got %0d expected 1", stl0);
        end
        n_cmp++;
        if (stl1 !== 32'd3) begin
            n_fail++;
            $display("[TB] FAIL load_use_stall_lb3: got %0d expected 3", stl1);
        end
    endtask

    task automatic test_r0_unused();
        set_load_use(5'd0);
        settle();
        n_cmp++;
        if (ctl0 !== C_RUN) begin
            n_fail++;
            $display("[TB] FAIL r0_no_stall: got %b expected %b", ctl0, C_RUN);
        end
        advance();
        set_load_use(5'd9);
        id_use_rs = 1'b0; id_rt = 5'd3; id_use_rt = 1'b1;
        settle();
        n_cmp++;
        if (ctl1 !== C_RUN) begin
            n_fail++;
            $display("[TB] FAIL unused_rs_no_stall: got %b expected %b", ctl1, C_RUN);
        end
        advance();
        set_idle();
    endtask

    task automatic test_branch_beats_hazard();
        int unsigned f0;
        f0 = flushes[0];
        set_load_use(5'd12);
        exe_bj = 1'b1;
        settle();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (act_ctl(k) !== C_BRANCH) begin
                n_fail++;
                $display("[TB] FAIL branch_ctl dut%0d: got %b expected %b", k, act_ctl(k), C_BRANCH);
            end
        end
        advance();
        set_idle();
        settle();
        n_cmp++;
        if (fls0 !== 32'(f0 + 1)) begin
            n_fail++;
            $display("[TB] FAIL branch_flush_cnt: got %0d expected %0d", fls0, f0 + 1);
        end
        n_cmp++;
        if (ctl1 !== C_RUN) begin
            n_fail++;
            $display("[TB] FAIL branch_no_stall: got %b expected %b", ctl1, C_RUN);
        end
        advance();
    endtask

    task automatic test_mem_wait();
        int unsigned s0;
        s0 = stalls[0];
        mem_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            settle();
            n_cmp++;
            if (ctl0 !== C_FREEZE) begin
                n_fail++;
                $display("[TB] FAIL mem_wait_freeze cycle %0d: got %b expected %b", c, ctl0, C_FREEZE);
            end
            advance();
        end
        set_idle();
        settle();
        n_cmp++;
        if (stl0 !== 32'(s0 + 4)) begin
            n_fail++;
            $display("[TB] FAIL mem_wait_stall_cnt: got %0d expected %0d", stl0, s0 + 4);
        end
        n_cmp++;
        if (ctl0 !== C_RUN) begin
            n_fail++;
            $display("[TB] FAIL mem_wait_release: got %b expected %b", ctl0, C_RUN);
        end
        advance();
    endtask

    task automatic test_timeout();
        mem_req = 1'b1;
        mem_ack = 1'b0;
        for (int c = 0; c < TMO + 1; c++) begin
            settle();
            n_cmp++;
            if (err0 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL timeout_early_err cycle %0d: got %b expected 0", c, err0);
            end
            advance();
        end
        set_idle();
        settle();
        n_cmp++;
        if (err0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timeout_err_pulse: got %b expected 1", err0);
        end
        n_cmp++;
        if (ctl0 !== C_RUN) begin
            n_fail++;
            $display("[TB] FAIL timeout_release: got %b expected %b", ctl0, C_RUN);
        end
        advance();
        settle();
        n_cmp++;
        if (err0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_err_width: got %b expected 0", err0);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        set_load_use(5'd5);
        settle();
        advance();
        set_idle();
        rst = 1'b1;
        settle();
        n_cmp++;
        if (ctl1 !== C_RESET) begin
            n_fail++;
            $display("[TB] FAIL rst_stall_ctl: got %b expected %b", ctl1, C_RESET);
        end
        n_cmp++;
        if (stl1 !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_stall_cnt: got %0d expected 0", stl1);
        end
        advance();
        rst = 1'b0;
        settle();
        n_cmp++;
        if (ctl1 !== C_RUN) begin
            n_fail++;
            $display("[TB] FAIL rst_stall_resume: got %b expected %b", ctl1, C_RUN);
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom);
            id_use_rt   = 1'($urandom);
            exe_mem_rd  = 1'($urandom);
            exe_wb_we   = ($urandom_range(0, 3) != 0);
            exe_wb_dreg = 5'($urandom_range(0, 3));
            exe_bj      = ($urandom_range(0, 7) == 0);
            mem_req     = ($urandom_range(0, 5) == 0) || (mem_req && $urandom_range(0, 3) != 0);
            mem_ack     = mem_req && ($urandom_range(0, 2) == 0);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act_ctl(k) !== exp_ctl[k]) begin
                    n_fail++;
                    $display("[TB] FAIL rand_ctl dut%0d cycle %0d: got %b expected %b",
                             k, c, act_ctl(k), exp_ctl[k]);
                end
                n_cmp++;
                if (act_err(k) !== err_q[k]) begin
                    n_fail++;
                    $display("[TB] FAIL rand_err dut%0d cycle %0d: got %b expected %b",
                             k, c, act_err(k), err_q[k]);
                end
                n_cmp++;
                if (act_stl(k) !== 32'(stalls[k])) begin
                    n_fail++;
                    $display("[TB] FAIL rand_stall dut%0d cycle %0d: got %0d expected %0d",
                             k, c, act_stl(k), stalls[k]);
                end
                n_cmp++;
                if (act_fls(k) !== 32'(flushes[k])) begin
                    n_fail++;
                    $display("[TB] FAIL rand_flush dut%0d cycle %0d: got %0d expected %0d",
                             k, c, act_fls(k), flushes[k]);
                end
            end
            advance();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_r0_unused();
        test_branch_beats_hazard();
        test_mem_wait();
        test_timeout();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
